// File: rtl/mul32_arbiter.sv
// Two-requester round-robin front end for a LAT-stage 32x32 multiplier; grant is combinational,
// response arrives LAT+2 cycles after the handshake with no response backpressure.
module mul32_arbiter #(
  parameter int LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        req0_valid,
  input  logic        req1_valid,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        req0_ready,
  output logic        req1_ready,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic        mul_in_valid,
  input  logic [63:0] mul_p,
  output logic [63:0] resp_p,
  output logic        resp0_valid,
  output logic        resp1_valid,
  output logic        busy,
  output logic [31:0] ops_count
);

  logic           last_grant_q, last_grant_d;
  logic           gnt0, gnt1, hs;
  logic [31:0]    mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic           mul_vld_q, mul_id_q, mul_id_d;
  logic [LAT-1:0] tag_vld_q, tag_id_q;
  logic [63:0]    resp_p_q, resp_p_d;
  logic           resp0_vld_q, resp1_vld_q;
  logic [31:0]    ops_count_q, ops_count_d;

  // last_grant_q == 1 means requester 0 has priority on contention; gating
  // with rst keeps both readies low while reset is held.
  assign gnt0 = rst & en & req0_valid & (~req1_valid | last_grant_q);
  assign gnt1 = rst & en & req1_valid & (~req0_valid | ~last_grant_q);
  assign hs   = gnt0 | gnt1;

  always_comb begin
    last_grant_d = last_grant_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    mul_id_d     = mul_id_q;
    resp_p_d     = resp_p_q;
    ops_count_d  = ops_count_q + {31'd0, hs};
    if (hs) begin
      last_grant_d = gnt1;
      mul_id_d     = gnt1;
      mul_a_d      = gnt1 ? req1_a : req0_a;
      mul_b_d      = gnt1 ? req1_b : req0_b;
    end
    if (tag_vld_q[LAT-1]) begin
      resp_p_d = mul_p;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= 1'b1;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      mul_vld_q    <= 1'b0;
      mul_id_q     <= 1'b0;
      tag_vld_q    <= '0;
      tag_id_q     <= '0;
      resp_p_q     <= '0;
      resp0_vld_q  <= 1'b0;
      resp1_vld_q  <= 1'b0;
      ops_count_q  <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      mul_vld_q    <= hs;
      mul_id_q     <= mul_id_d;
      tag_vld_q[0] <= mul_vld_q;
      tag_id_q[0]  <= mul_id_q;
      for (int i = 1; i < LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_id_q[i]  <= tag_id_q[i-1];
      end
      resp_p_q    <= resp_p_d;
      resp0_vld_q <= tag_vld_q[LAT-1] & ~tag_id_q[LAT-1];
      resp1_vld_q <= tag_vld_q[LAT-1] &  tag_id_q[LAT-1];
      ops_count_q <= ops_count_d;
    end
  end

  assign req0_ready   = gnt0;
  assign req1_ready   = gnt1;
  assign mul_a        = mul_a_q;
  assign mul_b        = mul_b_q;
  assign mul_in_valid = mul_vld_q;
  assign resp_p       = resp_p_q;
  assign resp0_valid  = resp0_vld_q;
  assign resp1_valid  = resp1_vld_q;
  assign busy         = mul_vld_q | (|tag_vld_q) | resp0_vld_q | resp1_vld_q;
  assign ops_count    = ops_count_q;

endmodule

// File: tb/tb_mul32_arbiter.sv
// Directed bench for mul32_arbiter with a behavioural LAT-stage multiplier and response scoreboard.
module tb_mul32_arbiter;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst, en, req0_valid, req1_valid;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_ready, req1_ready, mul_in_valid, resp0_valid, resp1_valid, busy;
  logic [31:0] mul_a, mul_b, ops_count;
  logic [63:0] mul_p, resp_p;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int resp_cnt = 0;
  logic [31:0] exp_ops = '0;

  mul32_arbiter #(.LAT(LAT)) dut (
    .clk(clk), .rst(rst), .en(en),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .mul_a(mul_a), .mul_b(mul_b), .mul_in_valid(mul_in_valid), .mul_p(mul_p),
    .resp_p(resp_p), .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
    .busy(busy), .ops_count(ops_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Behavioural multiplier: product appears LAT cycles after the operands.
  logic [63:0] p_pipe [LAT];
  always @(posedge clk) begin
    p_pipe[0] <= 64'(mul_a) * 64'(mul_b);
    for (int i = 1; i < LAT; i++) p_pipe[i] <= p_pipe[i-1];
  end
  assign mul_p = p_pipe[LAT-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  typedef struct {
    logic        id;
    logic [63:0] p;
    int          c;
  } exp_t;
  exp_t sb[$];

  // Scoreboard: issue order, owner, product, latency, counter and grant invariants.
  always @(negedge clk) begin
    if (!rst) begin
      sb.delete();
      exp_ops = '0;
      chk("ready_in_reset", {62'd0, req0_ready, req1_ready}, 64'd0);
    end else begin
      chk("ops_count", ops_count, exp_ops);
      chk("ready_exclusive", req0_ready & req1_ready, 0);
      if (!en) chk("ready_while_en0", req0_ready | req1_ready, 0);
      chk("resp_exclusive", resp0_valid & resp1_valid, 0);
      if (resp0_valid || resp1_valid) begin
        resp_cnt++;
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL resp_unexpected: got response %0h with nothing in flight (cycle %0d)", resp_p, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("resp_owner", resp1_valid, e.id);
          chk("resp_p", resp_p, e.p);
          chk("resp_latency", cyc - e.c, LAT + 2);
        end
      end
      if (req0_valid && req0_ready) begin
        sb.push_back('{1'b0, 64'(req0_a) * 64'(req0_b), cyc});
        exp_ops++;
      end
      if (req1_valid && req1_ready) begin
        sb.push_back('{1'b1, 64'(req1_a) * 64'(req1_b), cyc});
        exp_ops++;
      end
    end
  end

  typedef struct {
    logic        id;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
  } vec_t;
  vec_t vecs [5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 32'd3, 32'd5, 64'd15};
    vecs[1] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    vecs[2] = '{1'b0, 32'h0, 32'hFFFF_FFFF, 64'h0};
    vecs[3] = '{1'b1, 32'h0001_0000, 32'h0001_0000, 64'h1_0000_0000};
    vecs[4] = '{1'b0, 32'h1234_5678, 32'h10, 64'h1_2345_6780};

    rst = 1'b0; en = 1'b1; req0_valid = 0; req1_valid = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    tick(); tick();
    chk("rst_mul_in_valid", mul_in_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_resp_valid", {resp0_valid, resp1_valid}, 0);
    chk("rst_mul_ab", {mul_a, mul_b}, 0);
    chk("rst_resp_p", resp_p, 0);
    chk("rst_ops_count", ops_count, 0);

    // Contention from reset release: requester 0 wins first, then strict alternation.
    req0_valid = 1; req0_a = 2; req0_b = 2;
    req1_valid = 1; req1_a = 7; req1_b = 9;
    #1 chk("rst_ready_held", {req0_ready, req1_ready}, 0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("contend_ready0", req0_ready, (i % 2 == 0));
      chk("contend_ready1", req1_ready, (i % 2 == 1));
      tick();
    end
    req0_valid = 0; req1_valid = 0;
    repeat (LAT + 4) tick();
    chk("contend_resp_count", resp_cnt, 8);

    // Single-issue table with hand-computed products.
    for (int v = 0; v < 5; v++) begin
      if (vecs[v].id) begin req1_valid = 1; req1_a = vecs[v].a; req1_b = vecs[v].b; end
      else            begin req0_valid = 1; req0_a = vecs[v].a; req0_b = vecs[v].b; end
      #1 chk("single_ready", {req1_ready, req0_ready}, vecs[v].id ? 2'b10 : 2'b01);
      tick();
      req0_valid = 0; req1_valid = 0;
      req0_a = 32'hDEAD_BEEF; req0_b = 32'hDEAD_BEEF; req1_a = 32'hDEAD_BEEF; req1_b = 32'hDEAD_BEEF;
      chk("single_mul_in_valid", mul_in_valid, 1);
      chk("single_mul_ab", {mul_a, mul_b}, {vecs[v].a, vecs[v].b});
      tick();
      chk("single_mul_idle", mul_in_valid, 0);
      chk("single_mul_ab_hold", {mul_a, mul_b}, {vecs[v].a, vecs[v].b});
      repeat (LAT) tick();
      chk("single_resp_valid", {resp1_valid, resp0_valid}, vecs[v].id ? 2'b10 : 2'b01);
      chk("single_resp_p", resp_p, vecs[v].p);
      chk("single_busy_high", busy, 1);
      tick();
      chk("single_busy_low", busy, 0);
      chk("single_resp_clear", {resp1_valid, resp0_valid}, 0);
      chk("single_resp_hold", resp_p, vecs[v].p);
    end
    chk("ops_after_single", ops_count, 13);

    // Three back-to-back grants, then en low for ten cycles.
    begin
      int r0;
      for (int k = 0; k < 3; k++) begin
        req0_valid = 1; req0_a = k + 1; req0_b = k + 10;
        #1 chk("b2b_ready0", req0_ready, 1);
        tick();
      end
      en = 0; req1_valid = 1; req1_a = 5; req1_b = 5;
      r0 = resp_cnt;
      for (int k = 0; k < 10; k++) begin
        #1 chk("en0_no_ready", {req0_ready, req1_ready}, 0);
        tick();
      end
      chk("en0_resp_count", resp_cnt - r0, 3);
      chk("en0_busy_idle", busy, 0);
      req0_valid = 0; req1_valid = 0; en = 1;
      tick();
    end

    // Reset two cycles after two accepted requests discards them.
    begin
      int r0;
      req0_valid = 1; req0_a = 11; req0_b = 13;
      tick();
      req0_valid = 0; req1_valid = 1; req1_a = 17; req1_b = 19;
      tick();
      req1_valid = 0;
      tick();
      rst = 1'b0;
      #1;
      chk("midrst_mul_in_valid", mul_in_valid, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_mul_ab", {mul_a, mul_b}, 0);
      chk("midrst_resp_p", resp_p, 0);
      chk("midrst_ops_count", ops_count, 0);
      r0 = resp_cnt;
      tick();
      rst = 1'b1;
      repeat (LAT + 6) tick();
      chk("midrst_no_resp", resp_cnt - r0, 0);
      chk("midrst_busy_after", busy, 0);
    end

    // Counter wrap from all-ones.
    force dut.ops_count_q = 32'hFFFF_FFFF;
    exp_ops = 32'hFFFF_FFFF;
    #1 release dut.ops_count_q;
    chk("wrap_preload", ops_count, 32'hFFFF_FFFF);
    req1_valid = 1; req1_a = 6; req1_b = 7;
    tick();
    req1_valid = 0;
    chk("wrap_ops_count", ops_count, 0);
    repeat (LAT + 4) tick();
    chk("scoreboard_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
